// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared bus encodings (sel operations, responder FSM states)
//               used by mem_responder and the bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam logic [1:0] SEL_NOP   = 2'b00;
    localparam logic [1:0] SEL_RD    = 2'b01;
    localparam logic [1:0] SEL_WR    = 2'b10;
    localparam logic [1:0] SEL_FETCH = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        FETCH_HI = 3'd2,
        RESP     = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module      : mem_array
// Description : DEPTH x 16 storage, synchronous write, two asynchronous read
//               ports at raddr and raddr+1 (wrapping modulo DEPTH).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata0,
    output logic [15:0]   rdata1
);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] w_raddr1;

    // AW-bit addition wraps naturally at DEPTH
    assign w_raddr1 = raddr + AW'(1);

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata0 = r_mem[raddr];
    assign rdata1 = r_mem[w_raddr1];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : 4-phase handshake memory responder (read/write/fetch/no-op).
//               Optional wait states when MEMR_WAIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  sel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [31:0] fetch_data,
    output logic        ready
);

    localparam int         c_aw        = $clog2(DEPTH);
    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);
`ifdef MEMR_WAIT_EN
    localparam logic       c_has_wait  = 1'b1;
    logic [3:0]            r_wait_cnt;
`else
    localparam logic       c_has_wait  = 1'b0;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sel;
    logic [c_aw-1:0] r_addr;
    logic [15:0]     r_wdata;
    logic [15:0]     r_fetch_lo;
    logic [15:0]     r_rdata_hold;
    logic [31:0]     r_fetch_hold;
    logic            w_resp;
    logic            w_we;
    logic [15:0]     w_rd0;
    logic [15:0]     w_rd1;

    // Reset in the RESP cycle suppresses both the pulse and the write
    assign w_resp = (r_state == RESP) && !reset;
    assign w_we   = w_resp && (r_sel == SEL_WR);

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_mem (
        .clk    (clk),
        .we     (w_we),
        .waddr  (r_addr),
        .wdata  (r_wdata),
        .raddr  (r_addr),
        .rdata0 (w_rd0),
        .rdata1 (w_rd1)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cs) begin
                    if (c_has_wait && (c_wait_load != 4'd0)) begin
                        w_next = WAIT;
                    end else if (sel == SEL_FETCH) begin
                        w_next = FETCH_HI;
                    end else begin
                        w_next = RESP;
                    end
                end
            end
`ifdef MEMR_WAIT_EN
            WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_next = (r_sel == SEL_FETCH) ? FETCH_HI : RESP;
                end
            end
`endif
            FETCH_HI: w_next = RESP;
            RESP:     w_next = DONE;
            DONE: begin
                if (!cs) begin
                    w_next = IDLE;
                end
            end
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= SEL_NOP;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_fetch_lo   <= '0;
            r_rdata_hold <= '0;
            r_fetch_hold <= '0;
`ifdef MEMR_WAIT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && cs) begin
                r_sel   <= sel;
                r_addr  <= addr[c_aw-1:0];
                r_wdata <= wdata;
`ifdef MEMR_WAIT_EN
                r_wait_cnt <= c_wait_load;
`endif
            end
`ifdef MEMR_WAIT_EN
            if (r_state == WAIT) begin
                r_wait_cnt <= (r_wait_cnt > 4'd1) ? (r_wait_cnt - 4'd1) : 4'd0;
            end
`endif
            if (r_state == FETCH_HI) begin
                r_fetch_lo <= w_rd0;
            end
            if (w_resp && (r_sel == SEL_RD)) begin
                r_rdata_hold <= w_rd0;
            end
            if (w_resp && (r_sel == SEL_FETCH)) begin
                r_fetch_hold <= {w_rd1, r_fetch_lo};
            end
        end
    end

    // Outputs show live data only in the RESP cycle, else the last result
    assign ready      = w_resp;
    assign rdata      = (w_resp && (r_sel == SEL_RD)) ? w_rd0 : r_rdata_hold;
    assign fetch_data = (w_resp && (r_sel == SEL_FETCH)) ? {w_rd1, r_fetch_lo}
                                                         : r_fetch_hold;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Randomized self-checking bench for mem_responder against a
//               transaction-level memory model (honours MEMR_WAIT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
    localparam logic [1:0] OP_NOP = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_FE = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [31:0] fetch_data;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_rdata;
    logic [31:0] exp_fetch;

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .sel        (sel),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .fetch_data (fetch_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int expected_latency(input logic [1:0] s);
        int lat;
        lat = (s == OP_FE) ? 2 : 1;
`ifdef MEMR_WAIT_EN
        lat += WAIT_CYCLES;
`endif
        return lat;
    endfunction

    // Called at posedge+1 with the responder idle and cs low
    task automatic run_txn(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d,
                           input int hold, input bit rst_in_resp);
        int lat;
        int k;
        bit seen;
        int idx;
        int idx1;
        lat  = expected_latency(s);
        idx  = int'(a) % DEPTH;
        idx1 = (idx + 1) % DEPTH;
        cs = 1'b1; sel = s; addr = a; wdata = d;
        @(posedge clk); #1;
        // inputs after capture must not matter
        sel = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        if (rst_in_resp) begin
            repeat (lat - 1) @(posedge clk);
            #1;
            reset = 1'b1;
            @(negedge clk);
            chk("rst_resp_ready", 32'(ready), 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            cs    = 1'b0;
            exp_rdata = '0;
            exp_fetch = '0;
            @(negedge clk);
            chk("rst_resp_rdata", 32'(rdata), 32'(exp_rdata));
            chk("rst_resp_fetch", fetch_data, exp_fetch);
            @(posedge clk); #1;
            return;
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (ready === 1'b1) seen = 1'b1;
        end
        chk("ready_seen", 32'(seen), 32'd1);
        chk("latency", 32'(k), 32'(lat));
        if (s == OP_RD) exp_rdata = model_mem[idx];
        if (s == OP_FE) exp_fetch = {model_mem[idx1], model_mem[idx]};
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("fetch_data", fetch_data, exp_fetch);
        if (s == OP_WR) model_mem[idx] = d;
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            chk("single_pulse", 32'(ready), 32'd0);
            chk("rdata_hold", 32'(rdata), 32'(exp_rdata));
            chk("fetch_hold", fetch_data, exp_fetch);
        end
        @(posedge clk); #1;
        cs = 1'b0; sel = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 1'b0; sel = OP_NOP; addr = '0; wdata = '0;
        exp_rdata = '0;
        exp_fetch = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_fetch", fetch_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Fill memory; upper address bits are noise that must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            run_txn(OP_WR, 16'(i + DEPTH * int'($urandom_range(0, 3))), 16'($urandom), 0, 1'b0);
        end

        run_txn(OP_WR, 16'h0010, 16'hBEEF, 0, 1'b0);
        run_txn(OP_RD, 16'h0010, 16'h0000, 0, 1'b0);
        chk("beef_read", 32'(rdata), 32'h0000_BEEF);

        run_txn(OP_WR, 16'h0020, 16'h1234, 0, 1'b0);
        run_txn(OP_WR, 16'h0021, 16'hABCD, 0, 1'b0);
        run_txn(OP_FE, 16'h0020, 16'h0000, 0, 1'b0);
        chk("fetch_20", fetch_data, 32'hABCD_1234);

        run_txn(OP_WR, 16'h00FF, 16'h1111, 0, 1'b0);
        run_txn(OP_WR, 16'h0000, 16'h2222, 0, 1'b0);
        run_txn(OP_FE, 16'h00FF, 16'h0000, 0, 1'b0);
        chk("fetch_wrap", fetch_data, 32'h2222_1111);

        run_txn(OP_RD, 16'h0020, 16'h0000, 10, 1'b0);
        run_txn(OP_RD, 16'h0021, 16'h0000, 0, 1'b0);

        run_txn(OP_WR, 16'h0005, 16'h5555, 0, 1'b1);
        run_txn(OP_RD, 16'h0005, 16'h0000, 0, 1'b0);
        run_txn(OP_NOP, 16'h0005, 16'h0000, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_txn(2'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
